// File: rtl/lsb_queue_pkg.sv
// rtl/lsb_queue_pkg.sv - shared types and constants for the load/store queue
package lsb_queue_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_typ_e;

  // Tag value meaning "no producer / no pending branch".
  localparam int NONE_TAG = 0;

  typedef struct packed {
    mem_typ_e    typ;
    logic [2:0]  op;
    logic [11:0] offset;
  } lsb_static_t;

  function automatic logic head_ready(input mem_typ_e typ, input logic qj_clear,
                                      input logic qk_clear, input logic qm_clear);
    return (typ == MEM_STORE) ? (qj_clear && qk_clear && qm_clear) : qj_clear;
  endfunction

endpackage

// File: rtl/lsb_queue_if.sv
// rtl/lsb_queue_if.sv - enqueue, broadcast, commit and memory-issue signals of the queue
interface lsb_queue_if #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush_input;
  logic             enq_valid;
  logic             enq_typ;
  logic [2:0]       enq_op;
  logic [31:0]      enq_Vj;
  logic [31:0]      enq_Vk;
  logic [ROB_W-1:0] enq_Qj;
  logic [ROB_W-1:0] enq_Qk;
  logic [ROB_W-1:0] enq_Qm;
  logic [ROB_W-1:0] enq_dest;
  logic [11:0]      enq_offset;
  logic [ROB_W-1:0] cdb_alu_rob_id;
  logic [ROB_W-1:0] cdb_mem_rob_id;
  logic [31:0]      cdb_alu_value;
  logic [31:0]      cdb_mem_value;
  logic [ROB_W-1:0] rob_commit_id;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_typ;
  logic [2:0]       mem_op;
  logic [31:0]      mem_Vj;
  logic [31:0]      mem_Vk;
  logic [11:0]      mem_offset;
  logic [ROB_W-1:0] mem_dest;

  modport master (
    output flush_input, enq_valid, enq_typ, enq_op, enq_Vj, enq_Vk, enq_Qj, enq_Qk,
           enq_Qm, enq_dest, enq_offset, cdb_alu_rob_id, cdb_mem_rob_id,
           cdb_alu_value, cdb_mem_value, rob_commit_id, mem_ready,
    input  full, almost_full, count, mem_valid, mem_typ, mem_op, mem_Vj, mem_Vk,
           mem_offset, mem_dest
  );

  modport slave (
    input  flush_input, enq_valid, enq_typ, enq_op, enq_Vj, enq_Vk, enq_Qj, enq_Qk,
           enq_Qm, enq_dest, enq_offset, cdb_alu_rob_id, cdb_mem_rob_id,
           cdb_alu_value, cdb_mem_value, rob_commit_id, mem_ready,
    output full, almost_full, count, mem_valid, mem_typ, mem_op, mem_Vj, mem_Vk,
           mem_offset, mem_dest
  );

endinterface

// File: rtl/lsb_entry_wakeup.sv
// rtl/lsb_entry_wakeup.sv - per-entry CDB operand capture and branch-commit tag clear
module lsb_entry_wakeup
  import lsb_queue_pkg::*;
#(
  parameter int ROB_W = 4
) (
  input  logic [ROB_W-1:0] qj_i,
  input  logic [ROB_W-1:0] qk_i,
  input  logic [ROB_W-1:0] qm_i,
  input  logic [31:0]      vj_i,
  input  logic [31:0]      vk_i,
  input  logic [ROB_W-1:0] alu_id_i,
  input  logic [31:0]      alu_val_i,
  input  logic [ROB_W-1:0] mem_id_i,
  input  logic [31:0]      mem_val_i,
  input  logic [ROB_W-1:0] commit_id_i,
  output logic [ROB_W-1:0] qj_o,
  output logic [ROB_W-1:0] qk_o,
  output logic [ROB_W-1:0] qm_o,
  output logic [31:0]      vj_o,
  output logic [31:0]      vk_o
);
  localparam logic [ROB_W-1:0] NONE = ROB_W'(NONE_TAG);

  always_comb begin
    qj_o = qj_i;
    vj_o = vj_i;
    qk_o = qk_i;
    vk_o = vk_i;
    qm_o = qm_i;
    if (qj_i != NONE && qj_i == alu_id_i) begin
      qj_o = NONE;
      vj_o = alu_val_i;
    end else if (qj_i != NONE && qj_i == mem_id_i) begin
      qj_o = NONE;
      vj_o = mem_val_i;
    end
    if (qk_i != NONE && qk_i == alu_id_i) begin
      qk_o = NONE;
      vk_o = alu_val_i;
    end else if (qk_i != NONE && qk_i == mem_id_i) begin
      qk_o = NONE;
      vk_o = mem_val_i;
    end
    if (qm_i != NONE && qm_i == commit_id_i) begin
      qm_o = NONE;
    end
  end

endmodule

// File: rtl/lsb_queue.sv
// rtl/lsb_queue.sv - in-order load/store queue with operand wakeup and head issue
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4
) (
  input  logic     clk_in,
  input  logic     rst_in,
  lsb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ROB_W-1:0] NONE = ROB_W'(NONE_TAG);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [ROB_W-1:0] qj_q [DEPTH];
  logic [ROB_W-1:0] qk_q [DEPTH];
  logic [ROB_W-1:0] qm_q [DEPTH];
  logic [ROB_W-1:0] dest_q [DEPTH];
  logic [31:0]      vj_q [DEPTH];
  logic [31:0]      vk_q [DEPTH];
  lsb_static_t      stat_q [DEPTH];

  logic [ROB_W-1:0] src_qj [DEPTH];
  logic [ROB_W-1:0] src_qk [DEPTH];
  logic [ROB_W-1:0] src_qm [DEPTH];
  logic [31:0]      src_vj [DEPTH];
  logic [31:0]      src_vk [DEPTH];
  logic [ROB_W-1:0] wk_qj [DEPTH];
  logic [ROB_W-1:0] wk_qk [DEPTH];
  logic [ROB_W-1:0] wk_qm [DEPTH];
  logic [31:0]      wk_vj [DEPTH];
  logic [31:0]      wk_vk [DEPTH];

  logic full, hd_ready, mem_valid, enq_fire, deq_fire;

  // Room is judged on the registered count only, so a same-edge dequeue never admits an enqueue.
  assign full      = (count_q == CW'(DEPTH));
  assign hd_ready  = head_ready(stat_q[head_q].typ, qj_q[head_q] == NONE,
                                qk_q[head_q] == NONE, qm_q[head_q] == NONE);
  assign mem_valid = valid_q[head_q] && hd_ready;
  assign enq_fire  = bus.enq_valid && !full;
  assign deq_fire  = mem_valid && bus.mem_ready;

  // The slot being written sees the incoming fields, so same-cycle broadcasts are caught on entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_qj[i] = qj_q[i];
      src_qk[i] = qk_q[i];
      src_qm[i] = qm_q[i];
      src_vj[i] = vj_q[i];
      src_vk[i] = vk_q[i];
      if (enq_fire && tail_q == PW'(i)) begin
        src_qj[i] = bus.enq_Qj;
        src_qk[i] = bus.enq_Qk;
        src_qm[i] = bus.enq_Qm;
        src_vj[i] = bus.enq_Vj;
        src_vk[i] = bus.enq_Vk;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_wk
    lsb_entry_wakeup #(.ROB_W(ROB_W)) u_wk (
      .qj_i        (src_qj[g]),
      .qk_i        (src_qk[g]),
      .qm_i        (src_qm[g]),
      .vj_i        (src_vj[g]),
      .vk_i        (src_vk[g]),
      .alu_id_i    (bus.cdb_alu_rob_id),
      .alu_val_i   (bus.cdb_alu_value),
      .mem_id_i    (bus.cdb_mem_rob_id),
      .mem_val_i   (bus.cdb_mem_value),
      .commit_id_i (bus.rob_commit_id),
      .qj_o        (wk_qj[g]),
      .qk_o        (wk_qk[g]),
      .qm_o        (wk_qm[g]),
      .vj_o        (wk_vj[g]),
      .vk_o        (wk_vk[g])
    );
  end

  always_comb begin
    head_d  = head_q + PW'(deq_fire);
    tail_d  = tail_q + PW'(enq_fire);
    count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    valid_d = valid_q;
    if (deq_fire) valid_d[head_q] = 1'b0;
    if (enq_fire) valid_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else if (bus.flush_input) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload and tags are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < DEPTH; i++) begin
      qj_q[i] <= wk_qj[i];
      qk_q[i] <= wk_qk[i];
      qm_q[i] <= wk_qm[i];
      vj_q[i] <= wk_vj[i];
      vk_q[i] <= wk_vk[i];
      if (enq_fire && tail_q == PW'(i)) begin
        stat_q[i] <= '{typ: mem_typ_e'(bus.enq_typ), op: bus.enq_op, offset: bus.enq_offset};
        dest_q[i] <= bus.enq_dest;
      end
    end
  end

  always_comb begin
    bus.full        = full;
    bus.almost_full = (count_q == CW'(DEPTH - 1));
    bus.count       = count_q;
    bus.mem_valid   = mem_valid;
    bus.mem_typ     = 1'b0;
    bus.mem_op      = '0;
    bus.mem_Vj      = '0;
    bus.mem_Vk      = '0;
    bus.mem_offset  = '0;
    bus.mem_dest    = '0;
    if (valid_q[head_q]) begin
      bus.mem_typ    = stat_q[head_q].typ;
      bus.mem_op     = stat_q[head_q].op;
      bus.mem_Vj     = vj_q[head_q];
      bus.mem_Vk     = (stat_q[head_q].typ == MEM_STORE) ? vk_q[head_q] : '0;
      bus.mem_offset = stat_q[head_q].offset;
      bus.mem_dest   = dest_q[head_q];
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// tb/tb_lsb_queue.sv - directed vectors, corner sequences and randomized model check for lsb_queue
module tb_lsb_queue;
  localparam int DEPTH = 8;
  localparam int ROB_W = 4;

  logic clk = 1'b0;
  logic rst;

  lsb_queue_if #(.DEPTH(DEPTH), .ROB_W(ROB_W)) bus ();

  lsb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit        typ;
    bit [2:0]  op;
    bit [31:0] vj, vk;
    bit [11:0] off;
    bit [3:0]  qj, qk, qm, dest;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    bit        flush, ev, typ;
    bit [3:0]  qj, qk, qm, dest;
    bit [31:0] vj;
    bit [3:0]  aid;
    bit [31:0] av;
    bit [3:0]  cm;
    bit        mr;
    int        ec;
    bit        emv;
    bit [3:0]  ed;
    bit [31:0] evj;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_input    = 0; bus.enq_valid = 0; bus.enq_typ = 0; bus.enq_op = 0;
    bus.enq_Vj         = 0; bus.enq_Vk = 0; bus.enq_Qj = 0; bus.enq_Qk = 0;
    bus.enq_Qm         = 0; bus.enq_dest = 0; bus.enq_offset = 0;
    bus.cdb_alu_rob_id = 0; bus.cdb_mem_rob_id = 0; bus.cdb_alu_value = 0;
    bus.cdb_mem_value  = 0; bus.rob_commit_id = 0; bus.mem_ready = 0;
  endtask

  task automatic enq_set(input bit typ, input bit [3:0] qj, input bit [3:0] qk,
                         input bit [3:0] qm, input bit [3:0] dest, input bit [31:0] vj);
    bus.enq_valid = 1; bus.enq_typ = typ; bus.enq_op = 3'd2; bus.enq_Vj = vj;
    bus.enq_Vk = 32'hAA; bus.enq_Qj = qj; bus.enq_Qk = qk; bus.enq_Qm = qm;
    bus.enq_dest = dest; bus.enq_offset = 12'd4;
  endtask

  function automatic vec_t mk(bit fl, bit ev, bit typ, bit [3:0] qj, bit [3:0] qk,
                              bit [3:0] qm, bit [3:0] dest, bit [31:0] vj, bit [3:0] aid,
                              bit [31:0] av, bit [3:0] cm, bit mr, int ec, bit emv,
                              bit [3:0] ed, bit [31:0] evj);
    vec_t v;
    v.flush = fl; v.ev = ev; v.typ = typ; v.qj = qj; v.qk = qk; v.qm = qm; v.dest = dest;
    v.vj = vj; v.aid = aid; v.av = av; v.cm = cm; v.mr = mr; v.ec = ec; v.emv = emv;
    v.ed = ed; v.evj = evj;
    return v;
  endfunction

  function automatic ent_t wake(ent_t e, bit [3:0] aid, bit [31:0] av, bit [3:0] mid,
                                bit [31:0] mv, bit [3:0] cm);
    if (e.qj != 0 && e.qj == aid) begin e.vj = av; e.qj = 0; end
    else if (e.qj != 0 && e.qj == mid) begin e.vj = mv; e.qj = 0; end
    if (e.qk != 0 && e.qk == aid) begin e.vk = av; e.qk = 0; end
    else if (e.qk != 0 && e.qk == mid) begin e.vk = mv; e.qk = 0; end
    if (e.qm != 0 && e.qm == cm) e.qm = 0;
    return e;
  endfunction

  function automatic bit ent_ready(ent_t e);
    return e.typ ? (e.qj == 0 && e.qk == 0 && e.qm == 0) : (e.qj == 0);
  endfunction

  task automatic check_model(input int c);
    ent_t h;
    bit   mv;
    h  = '{default: 0};
    mv = 0;
    if (mq.size() > 0) begin
      h  = mq[0];
      mv = ent_ready(h);
      if (!h.typ) h.vk = 0;
    end
    chk($sformatf("rnd%0d_count", c), 32'(bus.count), 32'(mq.size()));
    chk($sformatf("rnd%0d_full", c), 32'(bus.full), 32'(mq.size() == DEPTH));
    chk($sformatf("rnd%0d_afull", c), 32'(bus.almost_full), 32'(mq.size() == DEPTH - 1));
    chk($sformatf("rnd%0d_mem_valid", c), 32'(bus.mem_valid), 32'(mv));
    chk($sformatf("rnd%0d_typ", c), 32'(bus.mem_typ), 32'(h.typ));
    chk($sformatf("rnd%0d_op", c), 32'(bus.mem_op), 32'(h.op));
    chk($sformatf("rnd%0d_vj", c), bus.mem_Vj, h.vj);
    chk($sformatf("rnd%0d_vk", c), bus.mem_Vk, h.vk);
    chk($sformatf("rnd%0d_off", c), 32'(bus.mem_offset), 32'(h.off));
    chk($sformatf("rnd%0d_dest", c), 32'(bus.mem_dest), 32'(h.dest));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_dest", 32'(bus.mem_dest), 0);
    #2 rst = 1'b0;
    tick();

    tv[0]  = mk(0, 1, 0, 0, 0, 0, 3, 32'h100, 0, 0,     0, 1, 1, 1, 3, 32'h100);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 0,     0, 1, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 1, 5, 0, 0, 4, 0,       0, 0,     0, 1, 1, 0, 4, 0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,       5, 32'h20, 0, 0, 1, 1, 4, 32'h20);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 0,     0, 1, 0, 0, 0, 0);
    tv[5]  = mk(0, 1, 1, 0, 0, 7, 6, 32'h30,  0, 0,     0, 1, 1, 0, 6, 32'h30);
    tv[6]  = mk(0, 1, 0, 0, 0, 0, 2, 32'h40,  0, 0,     0, 1, 2, 0, 6, 32'h30);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 0,     7, 0, 2, 1, 6, 32'h30);
    tv[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 0,     0, 1, 1, 1, 2, 32'h40);
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 0,     0, 1, 0, 0, 0, 0);
    tv[10] = mk(0, 1, 0, 9, 0, 0, 1, 0,       9, 32'h55, 0, 0, 1, 1, 1, 32'h55);
    tv[11] = mk(1, 1, 0, 0, 0, 0, 5, 32'h77,  0, 0,     0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      idle();
      if (tv[i].ev) enq_set(tv[i].typ, tv[i].qj, tv[i].qk, tv[i].qm, tv[i].dest, tv[i].vj);
      bus.flush_input    = tv[i].flush;
      bus.cdb_alu_rob_id = tv[i].aid;
      bus.cdb_alu_value  = tv[i].av;
      bus.rob_commit_id  = tv[i].cm;
      bus.mem_ready      = tv[i].mr;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tv[i].ec));
      chk($sformatf("vec%0d_mem_valid", i), 32'(bus.mem_valid), 32'(tv[i].emv));
      chk($sformatf("vec%0d_dest", i), 32'(bus.mem_dest), 32'(tv[i].ed));
      chk($sformatf("vec%0d_vj", i), bus.mem_Vj, tv[i].evj);
    end

    // Offset the pointers by one, then run full fill/drain rounds so both pointers wrap.
    idle();
    enq_set(0, 0, 0, 0, 4'd14, 0);
    tick();
    idle();
    bus.mem_ready = 1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idle();
        enq_set(0, 0, 0, 0, 4'((r * 3 + k) % 15 + 1), 32'(k));
        tick();
        if (k == DEPTH - 2) chk($sformatf("wrap%0d_afull", r), 32'(bus.almost_full), 1);
      end
      chk($sformatf("wrap%0d_full", r), 32'(bus.full), 1);
      enq_set(0, 0, 0, 0, 4'd15, 0);
      tick();
      chk($sformatf("wrap%0d_drop_count", r), 32'(bus.count), DEPTH);
      chk($sformatf("wrap%0d_head0", r), 32'(bus.mem_dest), 32'((r * 3) % 15 + 1));
      bus.mem_ready = 1;
      tick();
      chk($sformatf("wrap%0d_fullsim_count", r), 32'(bus.count), DEPTH - 1);
      idle();
      bus.mem_ready = 1;
      for (int k = 1; k < DEPTH; k++) begin
        chk($sformatf("wrap%0d_order%0d", r, k), 32'(bus.mem_dest), 32'((r * 3 + k) % 15 + 1));
        tick();
      end
      chk($sformatf("wrap%0d_empty", r), 32'(bus.count), 0);
    end

    // Back-pressure: payload must hold, then flush empties.
    idle();
    enq_set(0, 0, 0, 0, 4'd9, 32'h1234);
    bus.enq_Vk = 32'hDEAD;
    bus.enq_offset = 12'h7FF;
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold%0d_valid", c), 32'(bus.mem_valid), 1);
      chk($sformatf("hold%0d_vj", c), bus.mem_Vj, 32'h1234);
      chk($sformatf("hold%0d_off", c), 32'(bus.mem_offset), 32'h7FF);
      chk($sformatf("hold%0d_load_vk", c), bus.mem_Vk, 0);
    end
    bus.flush_input = 1;
    tick();
    idle();
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_valid", 32'(bus.mem_valid), 0);

    // Asynchronous reset mid-handshake.
    enq_set(0, 0, 0, 0, 4'd3, 32'h99);
    tick();
    idle();
    bus.mem_ready = 1;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_valid", 32'(bus.mem_valid), 0);
    chk("arst_vj", bus.mem_Vj, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("arst_after_count", 32'(bus.count), 0);
    idle();
    enq_set(0, 0, 0, 0, 4'd5, 32'h5);
    tick();
    chk("arst_enq_valid", 32'(bus.mem_valid), 1);
    chk("arst_enq_dest", 32'(bus.mem_dest), 5);
    idle();
    bus.mem_ready = 1;
    tick();
    chk("arst_deq_count", 32'(bus.count), 0);

    // Randomized run against the queue model.
    idle();
    bus.flush_input = 1;
    tick();
    mq.delete();
    for (int c = 0; c < 800; c++) begin
      ent_t      e;
      bit        ev, fl, mr, deq;
      bit [3:0]  aid, mid, cm;
      bit [31:0] av, mv;
      check_model(c);
      ev  = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 99) == 0);
      mr  = ($urandom_range(0, 99) < 55);
      aid = 4'($urandom_range(0, 7));
      mid = 4'($urandom_range(0, 7));
      if (mid == aid) mid = 0;
      cm  = 4'($urandom_range(0, 7));
      av  = $urandom;
      mv  = $urandom;
      e.typ  = 1'($urandom_range(0, 1));
      e.op   = 3'($urandom_range(0, 7));
      e.vj   = $urandom;
      e.vk   = $urandom;
      e.off  = 12'($urandom);
      e.qj   = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 7));
      e.qk   = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 7));
      e.qm   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      e.dest = 4'($urandom_range(0, 15));
      bus.flush_input = fl; bus.enq_valid = ev; bus.enq_typ = e.typ; bus.enq_op = e.op;
      bus.enq_Vj = e.vj; bus.enq_Vk = e.vk; bus.enq_Qj = e.qj; bus.enq_Qk = e.qk;
      bus.enq_Qm = e.qm; bus.enq_dest = e.dest; bus.enq_offset = e.off;
      bus.cdb_alu_rob_id = aid; bus.cdb_alu_value = av; bus.cdb_mem_rob_id = mid;
      bus.cdb_mem_value = mv; bus.rob_commit_id = cm; bus.mem_ready = mr;
      if (fl) begin
        mq.delete();
      end else begin
        deq = (mq.size() > 0) && ent_ready(mq[0]) && mr;
        ev  = ev && (mq.size() < DEPTH);
        foreach (mq[i]) mq[i] = wake(mq[i], aid, av, mid, mv, cm);
        if (deq) void'(mq.pop_front());
        if (ev) mq.push_back(wake(e, aid, av, mid, mv, cm));
      end
      tick();
    end
    check_model(800);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
